alu_op_sequencer: RTL and testbench

- Command-level controller sitting between the host/test interface and the 8-bit operand register pair + ALU datapath.
- Accepts one operation command (opcode, two operands, optional swap) per valid/ready handshake.
- Sequences the register-pair strobes (data, load A, load B, swap), holds the ALU opcode for the configured latency, captures result and flags, then presents them on a valid/ready response port.

---
 rtl/alu_pkg.sv | 34 +++
 rtl/alu_op_sequencer_if.sv | 31 +++
 rtl/alu_op_sequencer.sv | 135 +++++++++++++
 tb/tb_alu_op_sequencer.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU operation sequencer and its neighbours.
//   state_e    : sequencer FSM encoding
//   OP_*       : ALU opcode values (legal range 0..7)
//   FLAG_*     : bit positions inside the {N,Z,C,V} flag nibble
//   *_DEF      : default datapath widths
package alu_pkg;

  localparam int WIDTH_DEF = 8;
  localparam int OP_W_DEF  = 4;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD_A = 3'd1,
    ST_LOAD_B = 3'd2,
    ST_SWAP   = 3'd3,
    ST_EXEC   = 3'd4,
    ST_RESP   = 3'd5
  } state_e;

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_AND = 4'd2;
  localparam logic [3:0] OP_OR  = 4'd3;
  localparam logic [3:0] OP_XOR = 4'd4;
  localparam logic [3:0] OP_NOT = 4'd5;
  localparam logic [3:0] OP_SHL = 4'd6;
  localparam logic [3:0] OP_SHR = 4'd7;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

endpackage

// File: rtl/alu_op_sequencer_if.sv
// Command/response handshake bundle of the ALU operation sequencer.
//   cmd_* : one operation request (valid/ready), master -> slave
//   res_* : captured result, flags and error bit (valid/ready), slave -> master
// master = host / test side, slave = sequencer.
interface alu_op_sequencer_if #(
  parameter int WIDTH = 8,
  parameter int OP_W  = 4
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [OP_W-1:0]  cmd_op;
  logic [WIDTH-1:0] cmd_opa;
  logic [WIDTH-1:0] cmd_opb;
  logic             cmd_swap;

  logic             res_valid;
  logic             res_ready;
  logic [WIDTH-1:0] res_data;
  logic [3:0]       res_flags;
  logic             res_err;

  modport master (
    output cmd_valid, cmd_op, cmd_opa, cmd_opb, cmd_swap, res_ready,
    input  cmd_ready, res_valid, res_data, res_flags, res_err
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_opa, cmd_opb, cmd_swap, res_ready,
    output cmd_ready, res_valid, res_data, res_flags, res_err
  );
endinterface

// File: rtl/alu_op_sequencer.sv
// Command-level controller between a host port and the operand register
// pair + ALU datapath. One command is accepted in IDLE, then the register
// pair is loaded (A, B, optional swap), the opcode is held on the ALU for
// ALU_LATENCY cycles, and the result/flags are captured and offered on the
// response port until consumed.
// Ports:
//   clk, reset           : clock, async active-high reset (shared with regs)
//   bus                  : command/response handshake (slave side)
//   reg_data, reg_load_a,
//   reg_load_b, reg_swap : register-pair data and strobes (at most one high)
//   alu_op               : opcode to the ALU, zero outside EXEC
//   alu_result, alu_flags: ALU outputs sampled at the end of EXEC
//   busy                 : controller not idle
//   op_count             : completed responses, wraps
module alu_op_sequencer
  import alu_pkg::*;
#(
  parameter int WIDTH       = WIDTH_DEF,
  parameter int OP_W        = OP_W_DEF,
  parameter int NUM_OPS     = 8,
  parameter int ALU_LATENCY = 1,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             reset,
  alu_op_sequencer_if.slave bus,
  output logic [WIDTH-1:0] reg_data,
  output logic             reg_load_a,
  output logic             reg_load_b,
  output logic             reg_swap,
  output logic [OP_W-1:0]  alu_op,
  input  logic [WIDTH-1:0] alu_result,
  input  logic [3:0]       alu_flags,
  output logic             busy,
  output logic [CNT_W-1:0] op_count
);

  localparam logic [2:0] IDLE   = ST_IDLE;
  localparam logic [2:0] LOAD_A = ST_LOAD_A;
  localparam logic [2:0] LOAD_B = ST_LOAD_B;
  localparam logic [2:0] SWAP   = ST_SWAP;
  localparam logic [2:0] EXEC   = ST_EXEC;
  localparam logic [2:0] RESP   = ST_RESP;

  // Down-counter for the EXEC hold; reloaded with LATENCY-1 so that the
  // cycle where it reads zero is the last EXEC cycle.
  localparam int              LAT_W    = (ALU_LATENCY > 1) ? $clog2(ALU_LATENCY) : 1;
  localparam logic [LAT_W-1:0] LAT_INIT = LAT_W'(ALU_LATENCY - 1);

  // One extra bit so NUM_OPS == 2**OP_W still fits.
  localparam logic [OP_W:0] NUM_OPS_L = (OP_W + 1)'(NUM_OPS);

  logic [2:0]       state;
  logic [OP_W-1:0]  op_q;
  logic [WIDTH-1:0] opa_q, opb_q;
  logic             swap_q;
  logic [LAT_W-1:0] lat_cnt;
  logic [WIDTH-1:0] res_data_q;
  logic [3:0]       res_flags_q;
  logic             res_err_q;
  logic             op_legal;

  assign op_legal = ({1'b0, bus.cmd_op} < NUM_OPS_L);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      op_q        <= '0;
      opa_q       <= '0;
      opb_q       <= '0;
      swap_q      <= 1'b0;
      lat_cnt     <= '0;
      res_data_q  <= '0;
      res_flags_q <= '0;
      res_err_q   <= 1'b0;
      op_count    <= '0;
    end else begin
      case (state)
        IDLE: if (bus.cmd_valid) begin
          op_q   <= bus.cmd_op;
          opa_q  <= bus.cmd_opa;
          opb_q  <= bus.cmd_opb;
          swap_q <= bus.cmd_swap;
          if (op_legal) begin
            state <= LOAD_A;
          end else begin
            // Illegal opcode: answer immediately, datapath untouched.
            res_data_q  <= '0;
            res_flags_q <= '0;
            res_err_q   <= 1'b1;
            state       <= RESP;
          end
        end
        LOAD_A: state <= LOAD_B;
        LOAD_B: begin
          lat_cnt <= LAT_INIT;
          state   <= swap_q ? SWAP : EXEC;
        end
        SWAP: state <= EXEC;
        EXEC: begin
          if (lat_cnt == '0) begin
            res_data_q  <= alu_result;
            res_flags_q <= alu_flags;
            res_err_q   <= 1'b0;
            state       <= RESP;
          end else begin
            lat_cnt <= lat_cnt - 1'b1;
          end
        end
        RESP: if (bus.res_ready) begin
          op_count <= op_count + 1'b1;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Strobes decode straight from the state register so they fall as soon
  // as reset is asserted.
  assign bus.cmd_ready = (state == IDLE);
  assign bus.res_valid = (state == RESP);
  assign busy          = (state != IDLE);
  assign reg_load_a    = (state == LOAD_A);
  assign reg_load_b    = (state == LOAD_B);
  assign reg_swap      = (state == SWAP);
  assign reg_data      = (state == LOAD_A) ? opa_q :
                         (state == LOAD_B) ? opb_q : '0;
  assign alu_op        = (state == EXEC) ? op_q : '0;

  assign bus.res_data  = res_data_q;
  assign bus.res_flags = res_flags_q;
  assign bus.res_err   = res_err_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Self-checking bench: two sequencers (latency 1 / 16-bit count and
// latency 3 / 4-bit count), each with a behavioural register pair and ALU.
module tb_alu_op_sequencer;
  import alu_pkg::*;

  localparam int W = 8, OW = 4, LAT0 = 1, LAT1 = 3, CW1 = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  int total = 0, bad = 0;
  int cyc = 0, acc1 = 0, n1 = 0, exp_cnt0 = 0;

  typedef struct { logic [7:0] d; logic [3:0] f; logic e; } exp_t;
  typedef struct { logic [3:0] op; logic [7:0] a, b; logic sw; logic [7:0] d; logic err; } vec_t;
  exp_t q0[$], q1[$];
  vec_t tv[12];

  alu_op_sequencer_if #(.WIDTH(W), .OP_W(OW)) c0();
  alu_op_sequencer_if #(.WIDTH(W), .OP_W(OW)) c1();

  logic [W-1:0]   rd0, rd1, ra0, rb0, ra1, rb1, res0, res1;
  logic           la0, lb0, sw0, la1, lb1, sw1, busy0, busy1;
  logic [OW-1:0]  aop0, aop1;
  logic [3:0]     fl0, fl1;
  logic [15:0]    cnt0;
  logic [CW1-1:0] cnt1;

  alu_op_sequencer #(.WIDTH(W), .OP_W(OW), .NUM_OPS(8), .ALU_LATENCY(LAT0), .CNT_W(16)) dut0 (
    .clk(clk), .reset(reset), .bus(c0.slave), .reg_data(rd0), .reg_load_a(la0),
    .reg_load_b(lb0), .reg_swap(sw0), .alu_op(aop0), .alu_result(res0),
    .alu_flags(fl0), .busy(busy0), .op_count(cnt0));

  alu_op_sequencer #(.WIDTH(W), .OP_W(OW), .NUM_OPS(8), .ALU_LATENCY(LAT1), .CNT_W(CW1)) dut1 (
    .clk(clk), .reset(reset), .bus(c1.slave), .reg_data(rd1), .reg_load_a(la1),
    .reg_load_b(lb1), .reg_swap(sw1), .alu_op(aop1), .alu_result(res1),
    .alu_flags(fl1), .busy(busy1), .op_count(cnt1));

  // Behavioural ALU: returns {N,Z,C,V,result}; C is carry-out / borrow.
  function automatic logic [11:0] alu_m(input logic [3:0] op, input logic [7:0] a, b);
    logic [8:0] s;
    logic [7:0] r;
    logic c, v;
    s = '0; c = 1'b0; v = 1'b0;
    case (op)
      OP_ADD: begin s = {1'b0, a} + {1'b0, b}; c = s[8]; v = (a[7] == b[7]) && (s[7] != a[7]); end
      OP_SUB: begin s = {1'b0, a} - {1'b0, b}; c = s[8]; v = (a[7] != b[7]) && (s[7] != a[7]); end
      OP_AND: s = {1'b0, a & b};
      OP_OR:  s = {1'b0, a | b};
      OP_XOR: s = {1'b0, a ^ b};
      OP_NOT: s = {1'b0, ~a};
      OP_SHL: begin s = {a, 1'b0}; c = a[7]; end
      OP_SHR: begin s = {1'b0, a >> 1}; c = a[0]; end
      default: s = '0;
    endcase
    r = s[7:0];
    return {r[7], (r == 8'h00), c, v, r};
  endfunction

  assign {fl0, res0} = alu_m(aop0, ra0, rb0);
  assign {fl1, res1} = alu_m(aop1, ra1, rb1);

  // Behavioural register pairs.
  always_ff @(posedge clk or posedge reset)
    if (reset) begin ra0 <= '0; rb0 <= '0; end
    else if (la0) ra0 <= rd0;
    else if (lb0) rb0 <= rd0;
    else if (sw0) begin ra0 <= rb0; rb0 <= ra0; end

  always_ff @(posedge clk or posedge reset)
    if (reset) begin ra1 <= '0; rb1 <= '0; end
    else if (la1) ra1 <= rd1;
    else if (lb1) rb1 <= rd1;
    else if (sw1) begin ra1 <= rb1; rb1 <= ra1; end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h expected=%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Scoreboards: pop and compare on each response handshake.
  exp_t e0, e1;
  always @(negedge clk) begin
    if (!reset && c0.res_valid && c0.res_ready) begin
      if (q0.size() == 0) begin
        total++; bad++;
        $display("FAIL sb0_unexpected actual=%0h expected=none", c0.res_data);
      end else begin
        e0 = q0.pop_front();
        chk("res_data", {24'h0, c0.res_data}, {24'h0, e0.d});
        chk("res_flags", {28'h0, c0.res_flags}, {28'h0, e0.f});
        chk("res_err", {31'h0, c0.res_err}, {31'h0, e0.e});
        exp_cnt0++;
      end
    end
  end

  always @(negedge clk) begin
    if (!reset && c1.res_valid && c1.res_ready) begin
      if (q1.size() == 0) begin
        total++; bad++;
        $display("FAIL sb1_unexpected actual=%0h expected=none", c1.res_data);
      end else begin
        e1 = q1.pop_front();
        chk("wrap_data", {24'h0, c1.res_data}, {24'h0, e1.d});
        chk("wrap_flags", {28'h0, c1.res_flags}, {28'h0, e1.f});
        chk("wrap_cnt", {28'h0, cnt1}, n1 % 16);
        chk("wrap_lat", cyc - acc1, 3 + LAT1);
        n1++;
      end
    end
  end

  // One command on dut0 with res_ready high; checks per-cycle strobes.
  task automatic send0(input vec_t v);
    int k, explat;
    logic [11:0] m;
    logic [7:0] ea, eb;
    logic [14:0] ex;
    explat = v.err ? 1 : 3 + LAT0 + int'(v.sw);
    ea = v.sw ? v.b : v.a;
    eb = v.sw ? v.a : v.b;
    m  = alu_m(v.op, ea, eb);
    @(posedge clk); #1;
    c0.cmd_valid = 1'b1; c0.cmd_op = v.op; c0.cmd_opa = v.a; c0.cmd_opb = v.b;
    c0.cmd_swap = v.sw; c0.res_ready = 1'b1;
    k = 0;
    do begin @(negedge clk); k++; end while (!c0.cmd_ready && k < 40);
    chk("cmd_accept", {31'h0, c0.cmd_ready}, 32'h1);
    q0.push_back('{d: v.d, f: (v.err ? 4'h0 : m[11:8]), e: v.err});
    @(posedge clk); #1;
    // Command inputs are free to change once accepted.
    c0.cmd_valid = 1'b0; c0.cmd_op = 4'hF; c0.cmd_opa = ~v.a; c0.cmd_opb = ~v.b;
    for (k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (c0.res_valid) break;
      if (k == 1)              ex = {3'b100, v.a, 4'h0};
      else if (k == 2)         ex = {3'b010, v.b, 4'h0};
      else if (k == 3 && v.sw) ex = {3'b001, 8'h00, 4'h0};
      else begin
        ex = {3'b000, 8'h00, v.op};
        chk("regpair", {16'h0, ra0, rb0}, {16'h0, ea, eb});
      end
      chk("strobes", {17'h0, la0, lb0, sw0, rd0, aop0}, {17'h0, ex});
    end
    chk("latency", k, explat);
    chk("resp_quiet", {17'h0, la0, lb0, sw0, rd0, aop0}, 32'h0);
    @(posedge clk); #1;
    chk("op_count", {16'h0, cnt0}, exp_cnt0 & 32'hFFFF);
    chk("idle_after", {30'h0, busy0, c0.res_valid}, 32'h0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic [11:0] m;
    c0.cmd_valid = 0; c0.cmd_op = '0; c0.cmd_opa = '0; c0.cmd_opb = '0; c0.cmd_swap = 0; c0.res_ready = 0;
    c1.cmd_valid = 0; c1.cmd_op = '0; c1.cmd_opa = '0; c1.cmd_opb = '0; c1.cmd_swap = 0; c1.res_ready = 0;
    reset = 1'b1;

    tv[0]  = '{OP_ADD, 8'h05, 8'h03, 1'b0, 8'h08, 1'b0};
    tv[1]  = '{OP_SUB, 8'h03, 8'h05, 1'b1, 8'h02, 1'b0};
    tv[2]  = '{OP_AND, 8'hF0, 8'h3C, 1'b0, 8'h30, 1'b0};
    tv[3]  = '{OP_OR,  8'h0F, 8'h30, 1'b1, 8'h3F, 1'b0};
    tv[4]  = '{OP_XOR, 8'hAA, 8'hFF, 1'b0, 8'h55, 1'b0};
    tv[5]  = '{OP_NOT, 8'h0F, 8'h77, 1'b0, 8'hF0, 1'b0};
    tv[6]  = '{OP_SHL, 8'h81, 8'h00, 1'b0, 8'h02, 1'b0};
    tv[7]  = '{OP_SHR, 8'h00, 8'h81, 1'b1, 8'h40, 1'b0};
    tv[8]  = '{4'hA,   8'h12, 8'h34, 1'b0, 8'h00, 1'b1};
    tv[9]  = '{4'h8,   8'hFF, 8'hFF, 1'b1, 8'h00, 1'b1};
    tv[10] = '{OP_ADD, 8'hFF, 8'h01, 1'b0, 8'h00, 1'b0};
    tv[11] = '{OP_SUB, 8'h80, 8'h01, 1'b0, 8'h7F, 1'b0};

    repeat (2) @(posedge clk);
    #1;
    chk("reset_state0", {1'b0, la0, lb0, sw0, rd0, aop0, busy0, c0.res_valid, c0.res_err, c0.res_flags, c0.res_data},
        32'h0);
    chk("reset_cnt", {12'h0, cnt0, cnt1}, 32'h0);
    reset = 1'b0;

    for (int i = 0; i < 12; i++) send0(tv[i]);

    // Backpressure with a second command already waiting.
    @(posedge clk); #1;
    c0.cmd_valid = 1; c0.cmd_op = OP_XOR; c0.cmd_opa = 8'h0F; c0.cmd_opb = 8'hFF; c0.cmd_swap = 0;
    c0.res_ready = 0;
    n = 0;
    do begin @(negedge clk); n++; end while (!c0.cmd_ready && n < 40);
    m = alu_m(OP_XOR, 8'h0F, 8'hFF);
    q0.push_back('{d: 8'hF0, f: m[11:8], e: 1'b0});
    @(posedge clk); #1;
    c0.cmd_op = OP_OR; c0.cmd_opa = 8'h30; c0.cmd_opb = 8'h03;
    n = 0;
    do begin @(negedge clk); n++; end while (!c0.res_valid && n < 40);
    chk("bp_latency", n, 3 + LAT0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("bp_hold", {19'h0, c0.res_valid, c0.cmd_ready, la0, lb0, sw0, c0.res_data, c0.res_err},
          {19'h0, 1'b1, 1'b0, 3'b000, 8'hF0, 1'b0});
    end
    m = alu_m(OP_OR, 8'h30, 8'h03);
    q0.push_back('{d: 8'h33, f: m[11:8], e: 1'b0});
    @(posedge clk); #1;
    c0.res_ready = 1;
    @(negedge clk);
    chk("no_same_cycle_accept", {31'h0, c0.cmd_ready}, 32'h0);
    @(posedge clk);
    @(negedge clk);
    chk("accept_next_cycle", {31'h0, c0.cmd_ready}, 32'h1);
    @(posedge clk); #1;
    c0.cmd_valid = 0;
    @(negedge clk);
    chk("second_load_a", {23'h0, la0, rd0}, {23'h0, 1'b1, 8'h30});
    n = 0;
    while (busy0 && n < 40) begin @(negedge clk); n++; end
    chk("bp_drain", q0.size(), 0);
    chk("bp_count", {16'h0, cnt0}, exp_cnt0 & 32'hFFFF);

    // Reset while an ADD sits in EXEC.
    @(posedge clk); #1;
    c0.cmd_valid = 1; c0.cmd_op = OP_ADD; c0.cmd_opa = 8'h40; c0.cmd_opb = 8'h22; c0.cmd_swap = 0;
    n = 0;
    do begin @(negedge clk); n++; end while (!c0.cmd_ready && n < 40);
    q0.push_back('{d: 8'h62, f: 4'h0, e: 1'b0});
    @(posedge clk); #1;
    c0.cmd_valid = 0;
    repeat (3) @(negedge clk);
    chk("in_exec", {27'h0, busy0, aop0}, {27'h0, 1'b1, OP_ADD});
    #1 reset = 1'b1;
    #1;
    chk("midreset_strobes", {27'h0, la0, lb0, sw0, busy0, c0.res_valid}, 32'h0);
    chk("midreset_cnt", {16'h0, cnt0}, 32'h0);
    chk("midreset_regs", {16'h0, ra0, rb0}, 32'h0);
    q0.delete();
    exp_cnt0 = 0;
    @(posedge clk); #1;
    reset = 1'b0;
    send0('{OP_ADD, 8'h01, 8'h01, 1'b0, 8'h02, 1'b0});

    // Count wrap on the 4-bit / latency-3 instance, back to back.
    c1.cmd_valid = 1; c1.res_ready = 1;
    for (int i = 0; i < 16; i++) begin
      c1.cmd_op = OP_ADD; c1.cmd_opa = 8'(i * 3); c1.cmd_opb = 8'(i + 7); c1.cmd_swap = 0;
      n = 0;
      do begin @(negedge clk); n++; end while (!c1.cmd_ready && n < 40);
      chk("wrap_accept", {31'h0, c1.cmd_ready}, 32'h1);
      acc1 = cyc;
      m = alu_m(OP_ADD, 8'(i * 3), 8'(i + 7));
      q1.push_back('{d: 8'(i * 4 + 7), f: m[11:8], e: 1'b0});
      @(posedge clk); #1;
    end
    c1.cmd_valid = 0;
    n = 0;
    while (q1.size() != 0 && n < 40) begin @(negedge clk); n++; end
    chk("wrap_drain", q1.size(), 0);
    @(posedge clk); #1;
    chk("wrap_final_cnt", {28'h0, cnt1}, 32'h0);
    chk("wrap_responses", n1, 16);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
